// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
// Build option: define INST_MEM_FAULT_CHECK_EN to flag misaligned or
// out-of-range fetches with resp_err instead of wrapping the index.
`ifndef INST_MEM_DEFINES
`define INST_MEM_DEFINES
`define PC_START 64'h0000_0000_8000_0000
`define REG_BUS  64
`define INST_W   32
`define IM_IDLE  1'b0
`define IM_WAIT  1'b1
`endif

package inst_mem_responder_pkg;

    localparam int ADDR_W = `REG_BUS;
    localparam int INST_W = `INST_W;
    localparam logic [ADDR_W-1:0] PC_START_ADDR = `PC_START;

    typedef enum logic {
        S_IDLE = `IM_IDLE,
        S_WAIT = `IM_WAIT
    } fsm_state_e;

    // One buffered response: 32 + 64 + 1 bits.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } resp_t;

    // Select the 32-bit instruction from a 64-bit word (addr[2] = upper half).
    function automatic logic [INST_W-1:0] pick_half(input logic [63:0] word, input logic hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch request/response bus between the IF stage (master) and the
// instruction-memory responder (slave).
interface inst_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [63:0] resp_addr;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_addr, resp_err
    );
endinterface

// File: rtl/inst_resp_fifo.sv
// Small synchronous response FIFO; storage is cleared on reset so the head
// reads as zero until the first push.
module inst_resp_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: accepts one PC at a time, waits LATENCY
// cycles, reads the 64-bit backing array and queues {inst, addr, err}.
// Build option: INST_MEM_FAULT_CHECK_EN enables fetch-fault detection.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    inst_mem_responder_if.slave            bus,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
    input  logic [63:0]                    load_data
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 3;
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    logic [63:0]       mem [DEPTH_WORDS];
    fsm_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              accept, push, pop, fault;
    logic              fifo_full, fifo_empty;
    logic [FC_W-1:0]   fifo_count;
    resp_t             push_data, head;
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic [63:0]       word;
    logic [INST_W-1:0] inst_rd;
    logic              unused_bits;

    // Address decode of the latched request; the read is combinational so a
    // same-edge backdoor write to this word lands after the old data is pushed.
    assign off     = addr_q - PC_START_ADDR;
    assign idx     = off[IDX_W+2:3];
    assign word    = mem[idx];
    assign inst_rd = pick_half(word, addr_q[2]);

`ifdef INST_MEM_FAULT_CHECK_EN
    assign fault       = (addr_q[1:0] != 2'b00) || (addr_q < PC_START_ADDR) ||
                         (off[ADDR_W-1:IDX_W+3] != '0);
    assign unused_bits = ^off[2:0];
    assign bus.resp_err = !fifo_empty && head.err;
`else
    assign fault       = 1'b0;
    assign unused_bits = ^{addr_q[1:0], off[ADDR_W-1:IDX_W+3], off[2:0], head.err};
    assign bus.resp_err = 1'b0;
`endif

    assign push_data.inst = fault ? '0 : inst_rd;
    assign push_data.addr = addr_q;
    assign push_data.err  = fault;

    assign bus.req_ready  = rst && (state == S_IDLE) && (fifo_count < FC_W'(FIFO_DEPTH));
    assign accept         = bus.req_valid && bus.req_ready;
    assign pop            = !fifo_empty && bus.resp_ready;
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_inst  = fifo_empty ? '0 : head.inst;
    assign bus.resp_addr  = fifo_empty ? '0 : head.addr;

    // Backdoor preload port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_data;
    end

    // FSM state, wait counter and latched request address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) addr_q <= bus.req_addr;
        end
    end

    // Next state: WAIT lasts LATENCY cycles, pushing on its last one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (cnt == LAST_CNT) begin
                    push      = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    inst_resp_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for the streaming-rate scenario.
module tb_inst_mem_responder;
    import inst_mem_responder_pkg::*;

    localparam logic [63:0] PC = PC_START_ADDR;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en0 = 1'b0, load_en1 = 1'b0;
    logic [11:0] load_idx0 = '0, load_idx1 = '0;
    logic [63:0] load_data0 = '0, load_data1 = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    inst_mem_responder_if bus0();
    inst_mem_responder_if bus1();

    inst_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(2), .FIFO_DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .load_en(load_en0), .load_idx(load_idx0), .load_data(load_data0)
    );

    inst_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .load_en(load_en1), .load_idx(load_idx1), .load_data(load_data1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [11:0] i, input logic [63:0] d);
        load_en0 = 1'b1; load_idx0 = i; load_data0 = d;
        tick();
        load_en0 = 1'b0;
    endtask

    task automatic load1(input logic [11:0] i, input logic [63:0] d);
        load_en1 = 1'b1; load_idx1 = i; load_data1 = d;
        tick();
        load_en1 = 1'b0;
    endtask

    task automatic test_reset();
        bus0.req_valid = 0; bus0.req_addr = '0; bus0.resp_ready = 0;
        bus1.req_valid = 0; bus1.req_addr = '0; bus1.resp_ready = 0;
        rst = 1'b0;
        tick(); tick();
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus0.req_ready); end
        checks++; if (bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus0.resp_valid); end
        checks++; if (bus0.resp_inst !== 32'h0) begin errors++; $display("FAIL reset_resp_inst: got %h want 0", bus0.resp_inst); end
        checks++; if (bus0.resp_addr !== 64'h0) begin errors++; $display("FAIL reset_resp_addr: got %h want 0", bus0.resp_addr); end
        checks++; if (bus0.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", bus0.resp_err); end
        checks++; if (bus1.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_l1: got %b want 0", bus1.req_ready); end
        rst = 1'b1;
        #1;
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus0.req_ready); end
    endtask

    task automatic test_basic_fetch();
        load0(12'd0, 64'hDEADBEEF_00000013);
        bus0.resp_ready = 1; bus0.req_valid = 1; bus0.req_addr = PC;
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", bus0.req_ready); end
        tick();
        bus0.req_valid = 0;
        checks++; if (bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL basic_early1: got %b want 0", bus0.resp_valid); end
        tick();
        checks++; if (bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL basic_early2: got %b want 0", bus0.resp_valid); end
        tick();
        checks++; if (bus0.resp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus0.resp_valid); end
        checks++; if (bus0.resp_inst !== 32'h00000013) begin errors++; $display("FAIL basic_inst_lo: got %h want 00000013", bus0.resp_inst); end
        checks++; if (bus0.resp_addr !== PC) begin errors++; $display("FAIL basic_addr_lo: got %h want %h", bus0.resp_addr, PC); end
        checks++; if (bus0.resp_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus0.resp_err); end
        bus0.req_valid = 1; bus0.req_addr = PC + 64'd4;
        tick();
        bus0.req_valid = 0;
        tick(); tick();
        checks++; if (bus0.resp_inst !== 32'hDEADBEEF || bus0.resp_valid !== 1'b1) begin errors++; $display("FAIL basic_inst_hi: got %h/%b want deadbeef/1", bus0.resp_inst, bus0.resp_valid); end
        checks++; if (bus0.resp_addr !== PC + 64'd4) begin errors++; $display("FAIL basic_addr_hi: got %h want %h", bus0.resp_addr, PC + 64'd4); end
        tick();
        checks++; if (bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", bus0.resp_valid); end
    endtask

    task automatic test_back_to_back();
        load0(12'd1, 64'hCAFEF00D_12345678);
        bus0.resp_ready = 0; bus0.req_valid = 1; bus0.req_addr = PC;
        tick();
        bus0.req_addr = PC + 64'd4;
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", bus0.req_ready); end
        tick(); tick();
        checks++; if (bus0.resp_inst !== 32'h00000013 || bus0.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b want 00000013/1", bus0.resp_inst, bus0.req_ready); end
        tick();
        bus0.req_addr = PC + 64'd8;
        tick(); tick();
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", bus0.req_ready); end
        tick(); tick();
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_held_off: got %b want 0", bus0.req_ready); end
        checks++; if (bus0.resp_inst !== 32'h00000013 || bus0.resp_addr !== PC) begin errors++; $display("FAIL b2b_stable: got %h/%h want 00000013/%h", bus0.resp_inst, bus0.resp_addr, PC); end
        bus0.resp_ready = 1;
        tick();
        checks++; if (bus0.resp_inst !== 32'hDEADBEEF || bus0.resp_addr !== PC + 64'd4) begin errors++; $display("FAIL b2b_second: got %h/%h want deadbeef", bus0.resp_inst, bus0.resp_addr); end
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen: got %b want 1", bus0.req_ready); end
        tick();
        bus0.req_valid = 0;
        checks++; if (bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", bus0.resp_valid); end
        tick(); tick();
        checks++; if (bus0.resp_inst !== 32'h12345678 || bus0.resp_addr !== PC + 64'd8) begin errors++; $display("FAIL b2b_third: got %h/%h want 12345678", bus0.resp_inst, bus0.resp_addr); end
        tick();
        checks++; if (bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", bus0.resp_valid); end
    endtask

    task automatic test_reset_inflight();
        logic seen;
        bus0.resp_ready = 1; bus0.req_valid = 1; bus0.req_addr = PC;
        tick();
        bus0.req_valid = 0;
        rst = 1'b0;
        tick();
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL rst_wait_ready_low: got %b want 0", bus0.req_ready); end
        rst = 1'b1;
        #1;
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b want 1", bus0.req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus0.resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_dropped: got resp_valid=1 want never"); end
    endtask

    task automatic test_read_before_write();
        load0(12'd5, 64'h11111111_AAAAAAAA);
        bus0.resp_ready = 1; bus0.req_valid = 1; bus0.req_addr = PC + 64'd40;
        tick();
        bus0.req_valid = 0;
        tick();
        load_en0 = 1; load_idx0 = 12'd5; load_data0 = 64'h22222222_BBBBBBBB;
        tick();
        load_en0 = 0;
        checks++; if (bus0.resp_inst !== 32'hAAAAAAAA || bus0.resp_valid !== 1'b1) begin errors++; $display("FAIL rbw_old: got %h/%b want aaaaaaaa/1", bus0.resp_inst, bus0.resp_valid); end
        tick();
        bus0.req_valid = 1;
        tick();
        bus0.req_valid = 0;
        tick(); tick();
        checks++; if (bus0.resp_inst !== 32'hBBBBBBBB || bus0.resp_addr !== PC + 64'd40) begin errors++; $display("FAIL rbw_new: got %h/%h want bbbbbbbb", bus0.resp_inst, bus0.resp_addr); end
        tick();
    endtask

    task automatic test_fault();
        logic [63:0] addrs [3];
        logic [31:0] exp_inst [3];
        logic        exp_err [3];
        load0(12'd4095, 64'h0BADC0DE_55555555);
        addrs[0] = PC + 64'd2;
        addrs[1] = PC - 64'd4;
        addrs[2] = PC + 64'd32768;
`ifdef INST_MEM_FAULT_CHECK_EN
        exp_inst[0] = 32'h0; exp_err[0] = 1'b1;
        exp_inst[1] = 32'h0; exp_err[1] = 1'b1;
        exp_inst[2] = 32'h0; exp_err[2] = 1'b1;
`else
        exp_inst[0] = 32'h00000013; exp_err[0] = 1'b0;
        exp_inst[1] = 32'h0BADC0DE; exp_err[1] = 1'b0;
        exp_inst[2] = 32'h00000013; exp_err[2] = 1'b0;
`endif
        bus0.resp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus0.req_valid = 1; bus0.req_addr = addrs[i];
            tick();
            bus0.req_valid = 0;
            tick(); tick();
            checks++; if (bus0.resp_inst !== exp_inst[i] || bus0.resp_valid !== 1'b1) begin errors++; $display("FAIL fault_inst%0d: got %h/%b want %h/1", i, bus0.resp_inst, bus0.resp_valid, exp_inst[i]); end
            checks++; if (bus0.resp_err !== exp_err[i]) begin errors++; $display("FAIL fault_err%0d: got %b want %b", i, bus0.resp_err, exp_err[i]); end
            checks++; if (bus0.resp_addr !== addrs[i]) begin errors++; $display("FAIL fault_addr%0d: got %h want %h", i, bus0.resp_addr, addrs[i]); end
            tick();
        end
    endtask

    task automatic test_latency1_stream();
        load1(12'd0, 64'h00000002_00000001);
        load1(12'd1, 64'h00000004_00000003);
        bus1.resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus1.req_valid = 1; bus1.req_addr = PC + 64'(4 * i);
            checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL l1_ready%0d: got %b want 1", i, bus1.req_ready); end
            tick();
            checks++; if (bus1.resp_valid !== 1'b0 || bus1.req_ready !== 1'b0) begin errors++; $display("FAIL l1_wait%0d: got %b/%b want 0/0", i, bus1.resp_valid, bus1.req_ready); end
            tick();
            checks++; if (bus1.resp_valid !== 1'b1 || bus1.resp_inst !== 32'(i + 1)) begin errors++; $display("FAIL l1_resp%0d: got %b/%h want 1/%h", i, bus1.resp_valid, bus1.resp_inst, 32'(i + 1)); end
        end
        bus1.req_valid = 0;
        tick();
        checks++; if (bus1.resp_valid !== 1'b0) begin errors++; $display("FAIL l1_drained: got %b want 0", bus1.resp_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_reset_inflight();
        test_read_before_write();
        test_fault();
        test_latency1_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
